// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine customer driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vend_pkg;

    // Driver FSM states; DONE is the single-cycle report state.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COIN,
        GAP,
        WAIT,
        DONE
    } state_t;

    // Money is counted in half-yuan units throughout.
    localparam int COIN_FULL      = 2;
    localparam int COIN_HALF      = 1;
    localparam int PRICE_HALF_DEF = 5;
    localparam int PLAN_MAX       = 8;

    // A plan longer than the 8-bit coin vector is cut down to 8 coins.
    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (len > 4'(PLAN_MAX)) ? 4'(PLAN_MAX) : len;
    endfunction

endpackage

// File: rtl/vend_payer.sv
// Replays a latched coin plan into the vending FSM and grades the vend and change.
// Latency: first coin 2 cycles after start, then one coin every GAP_CYC+1 cycles.
// Backpressure: none; start is dropped while busy, coke stops the plan early.
module vend_payer
    import vend_pkg::*;
#(
    parameter int PRICE_HALF = PRICE_HALF_DEF,
    parameter int GAP_CYC    = 2,
    parameter int TIMEOUT    = 8,
    parameter int CNT_W      = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [7:0]       plan_bits,
    input  logic [3:0]       plan_len,
    input  logic             coke,
    input  logic             ret,
    output logic             pay,
    output logic             pay_half,
    output logic             busy,
    output logic             done,
    output logic             vend_ok,
    output logic             change_ok,
    output logic             err_timeout,
    output logic [CNT_W-1:0] paid_half
);

    localparam logic [CNT_W-1:0] PRICE_W = CNT_W'(PRICE_HALF);
    localparam logic [CNT_W-1:0] FULL_W  = CNT_W'(COIN_FULL);
    localparam logic [CNT_W-1:0] HALF_W  = CNT_W'(COIN_HALF);

    state_t           r_state;
    logic [7:0]       r_plan;
    logic [3:0]       r_rem;
    logic [3:0]       r_gap_cnt;
    logic [7:0]       r_to_cnt;
    logic             r_ret_seen;
    logic             r_pay;
    logic             r_pay_half;
    logic             r_busy;
    logic             r_done;
    logic             r_vend_ok;
    logic             r_change_ok;
    logic             r_err_timeout;
    logic [CNT_W-1:0] r_paid;

    logic [CNT_W-1:0] w_coin_val;
    logic [CNT_W-1:0] w_paid_nxt;
    logic             w_ret_nxt;
    logic             w_chg_on_coke;

    // Coin in flight is always counted, even when coke arrives in the same cycle,
    // so the change verdict on a coke edge must see the post-coin total.
    always_comb begin
        w_coin_val    = r_pay ? FULL_W : HALF_W;
        w_paid_nxt    = (r_state == COIN) ? (r_paid + w_coin_val) : r_paid;
        w_ret_nxt     = r_ret_seen | ret;
        w_chg_on_coke = (w_ret_nxt == (w_paid_nxt > PRICE_W));
    end

    // Driver FSM with all outputs registered; coke preempts every busy-state action.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= IDLE;
            r_plan        <= '0;
            r_rem         <= '0;
            r_gap_cnt     <= '0;
            r_to_cnt      <= '0;
            r_ret_seen    <= 1'b0;
            r_pay         <= 1'b0;
            r_pay_half    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_vend_ok     <= 1'b0;
            r_change_ok   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_paid        <= '0;
        end else begin
            r_pay      <= 1'b0;
            r_pay_half <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_plan        <= plan_bits;
                        r_rem         <= clamp_len(plan_len);
                        r_ret_seen    <= 1'b0;
                        r_vend_ok     <= 1'b0;
                        r_change_ok   <= 1'b0;
                        r_err_timeout <= 1'b0;
                        r_paid        <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= LOAD;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    if (r_state == COIN) begin
                        r_paid <= w_paid_nxt;
                    end
                    r_ret_seen <= w_ret_nxt;
                    if (coke) begin
                        // Any pulse that would launch on this edge is simply not issued.
                        r_vend_ok   <= 1'b1;
                        r_change_ok <= w_chg_on_coke;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        case (r_state)
                            LOAD: begin
                                if (r_rem == 4'd0) begin
                                    r_done  <= 1'b1;
                                    r_state <= DONE;
                                end else begin
                                    r_pay      <= r_plan[0];
                                    r_pay_half <= ~r_plan[0];
                                    r_state    <= COIN;
                                end
                            end
                            COIN: begin
                                r_plan    <= r_plan >> 1;
                                r_rem     <= r_rem - 4'd1;
                                r_gap_cnt <= 4'(GAP_CYC - 1);
                                r_state   <= GAP;
                            end
                            GAP: begin
                                if (r_gap_cnt != 4'd0) begin
                                    r_gap_cnt <= r_gap_cnt - 4'd1;
                                end else if (r_rem != 4'd0) begin
                                    r_pay      <= r_plan[0];
                                    r_pay_half <= ~r_plan[0];
                                    r_state    <= COIN;
                                end else begin
                                    r_to_cnt <= '0;
                                    r_state  <= WAIT;
                                end
                            end
                            WAIT: begin
                                if (r_to_cnt == 8'(TIMEOUT - 1)) begin
                                    r_err_timeout <= 1'b1;
                                    r_done        <= 1'b1;
                                    r_state       <= DONE;
                                end else begin
                                    r_to_cnt <= r_to_cnt + 8'd1;
                                end
                            end
                            default: r_state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign pay         = r_pay;
    assign pay_half    = r_pay_half;
    assign busy        = r_busy;
    assign done        = r_done;
    assign vend_ok     = r_vend_ok;
    assign change_ok   = r_change_ok;
    assign err_timeout = r_err_timeout;
    assign paid_half   = r_paid;

endmodule
